// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one read/byte-lane-write command, waits WAIT_CYCLES, then acks for one cycle.
// Ack arrives WAIT_CYCLES+1 cycles after the request; inputs are ignored outside IDLE. Define DMEM_OOR_ERR_EN for out-of-range errors.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] Address,
    input  logic [31:0] MWriteData,
    input  logic [3:0]  WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] MReadData,
    output logic        DataMem_Ack,
    output logic        DataMem_Err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0] mem [DEPTH];

    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  we_q;
    logic        re_q;
    logic [3:0]  cnt;

    logic        req;
    logic        acc_fire;
    logic        acc_oor;
    logic [29:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_we;
    logic        acc_re;
    logic [ADDR_WIDTH-1:0] acc_idx;

    assign req = ReadEnable | (|WriteEnable);

    // With zero wait states the access happens on the latching edge, so it must use the live inputs.
    assign acc_addr  = (state == S_IDLE) ? Address     : addr_q;
    assign acc_wdata = (state == S_IDLE) ? MWriteData  : wdata_q;
    assign acc_we    = (state == S_IDLE) ? WriteEnable : we_q;
    assign acc_re    = (state == S_IDLE) ? ReadEnable  : re_q;
    assign acc_idx   = acc_addr[ADDR_WIDTH-1:0];

`ifdef DMEM_OOR_ERR_EN
    assign acc_oor     = (acc_addr >> ADDR_WIDTH) != 30'd0;
    assign DataMem_Err = (state == S_ACK) && ((addr_q >> ADDR_WIDTH) != 30'd0);
`else
    logic unused_addr;
    assign unused_addr = ^acc_addr;
    assign acc_oor     = 1'b0;
    assign DataMem_Err = 1'b0;
`endif

    assign DataMem_Ack = (state == S_ACK);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                        acc_fire  = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_ACK;
                    acc_fire  = 1'b1;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // The array has no reset, so an edge seen while reset is held must not commit a write.
        if (reset) begin
            acc_fire = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            re_q    <= 1'b0;
            cnt     <= '0;
        end else if (state == S_IDLE && req) begin
            addr_q  <= Address;
            wdata_q <= MWriteData;
            we_q    <= WriteEnable;
            re_q    <= ReadEnable;
            cnt     <= WAIT_INIT;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt     <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (acc_fire && !acc_oor) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_we[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read samples the array before the same-edge write, giving pre-write data for combined commands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MReadData <= '0;
        end else if (acc_fire && acc_re) begin
            MReadData <= acc_oor ? 32'h0000_0000 : mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances (default, zero-wait, 4-bit address) share one request bus.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [1:0]  cur;

    logic [3:0]  we0, we1, we2;
    logic        re0, re1, re2;
    logic [31:0] rd0, rd1, rd2;
    logic        ack0, ack1, ack2;
    logic        err0, err1, err2;

    assign we0 = (cur == 2'd0) ? we : 4'd0;
    assign we1 = (cur == 2'd1) ? we : 4'd0;
    assign we2 = (cur == 2'd2) ? we : 4'd0;
    assign re0 = (cur == 2'd0) ? re : 1'b0;
    assign re1 = (cur == 2'd1) ? re : 1'b0;
    assign re2 = (cur == 2'd2) ? re : 1'b0;

    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut0 (
        .clock(clk), .reset(rst), .Address(addr), .MWriteData(wdata),
        .WriteEnable(we0), .ReadEnable(re0),
        .MReadData(rd0), .DataMem_Ack(ack0), .DataMem_Err(err0)
    );
    data_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut1 (
        .clock(clk), .reset(rst), .Address(addr), .MWriteData(wdata),
        .WriteEnable(we1), .ReadEnable(re1),
        .MReadData(rd1), .DataMem_Ack(ack1), .DataMem_Err(err1)
    );
    data_mem_responder #(.ADDR_WIDTH(4), .WAIT_CYCLES(1)) dut2 (
        .clock(clk), .reset(rst), .Address(addr), .MWriteData(wdata),
        .WriteEnable(we2), .ReadEnable(re2),
        .MReadData(rd2), .DataMem_Ack(ack2), .DataMem_Err(err2)
    );

    logic        ack_s;
    logic        err_s;
    logic [31:0] rd_s;
    always_comb begin
        ack_s = ack0;
        err_s = err0;
        rd_s  = rd0;
        case (cur)
            2'd1: begin ack_s = ack1; err_s = err1; rd_s = rd1; end
            2'd2: begin ack_s = ack2; err_s = err2; rd_s = rd2; end
            default: begin ack_s = ack0; err_s = err0; rd_s = rd0; end
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [3:0]  we;
        logic        re;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] s, input logic [3:0] w, input logic r,
                                input logic [29:0] a, input logic [31:0] d,
                                input logic [31:0] er, input int el, input logic ee);
        vec_t v;
        v.sel = s; v.we = w; v.re = r; v.addr = a; v.wdata = d;
        v.exp_rd = er; v.exp_lat = el; v.exp_err = ee;
        return v;
    endfunction

    // One transaction: drive in cycle 0, find the Ack cycle, drop enables the cycle after Ack, count stray Acks.
    task automatic txn(input logic [1:0] s, input logic [3:0] w, input logic r,
                       input logic [29:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rdv, output logic ev, output int extra);
        @(posedge clk); #1;
        cur = s; we = w; re = r; addr = a; wdata = d;
        lat = -1; rdv = 'x; ev = 1'bx; extra = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack_s) begin
                lat = c; rdv = rd_s; ev = err_s;
                break;
            end
        end
        @(posedge clk); #1;
        we = 4'd0; re = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack_s) extra++;
        end
    endtask

    vec_t vecs[15];
    logic oor;

    initial begin
        int          lat, extra, nack, first;
        logic [31:0] rdv;
        logic        ev;

`ifdef DMEM_OOR_ERR_EN
        oor = 1'b1;
`else
        oor = 1'b0;
`endif
        vecs[0]  = mk(0, 4'hF, 0, 30'h10, 32'hDEADBEEF, 32'h0,        2, 0);
        vecs[1]  = mk(0, 4'h0, 1, 30'h10, 32'h0,        32'hDEADBEEF, 2, 0);
        vecs[2]  = mk(0, 4'h4, 0, 30'h10, 32'h00AA0000, 32'hDEADBEEF, 2, 0);
        vecs[3]  = mk(0, 4'h0, 1, 30'h10, 32'h0,        32'hDEAABEEF, 2, 0);
        vecs[4]  = mk(0, 4'hF, 0, 30'h11, 32'hCAFEF00D, 32'hDEAABEEF, 2, 0);
        vecs[5]  = mk(0, 4'h9, 0, 30'h11, 32'h11AAAA22, 32'hDEAABEEF, 2, 0);
        vecs[6]  = mk(0, 4'h0, 1, 30'h11, 32'h0,        32'h11FEF022, 2, 0);
        vecs[7]  = mk(0, 4'hF, 1, 30'h10, 32'h01234567, 32'hDEAABEEF, 2, 0);
        vecs[8]  = mk(0, 4'h0, 1, 30'h10, 32'h0,        32'h01234567, 2, 0);
        vecs[9]  = mk(1, 4'hF, 0, 30'h07, 32'h13572468, 32'h0,        1, 0);
        vecs[10] = mk(1, 4'h0, 1, 30'h07, 32'h0,        32'h13572468, 1, 0);
        vecs[11] = mk(2, 4'hF, 0, 30'h03, 32'hA5A5A5A5, 32'h0,        2, 0);
        vecs[12] = mk(2, 4'hF, 0, 30'h13, 32'h00000055, 32'h0,        2, oor);
        vecs[13] = mk(2, 4'h0, 1, 30'h03, 32'h0, oor ? 32'hA5A5A5A5 : 32'h00000055, 2, 0);
        vecs[14] = mk(2, 4'h0, 1, 30'h13, 32'h0, oor ? 32'h00000000 : 32'h00000055, 2, oor);

        rst = 1'b1; cur = 2'd0; we = 4'd0; re = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset ack0", {31'd0, ack0}, 32'd0);
        check("reset ack1", {31'd0, ack1}, 32'd0);
        check("reset ack2", {31'd0, ack2}, 32'd0);
        check("reset rd0", rd0, 32'd0);
        check("reset rd1", rd1, 32'd0);
        check("reset rd2", rd2, 32'd0);
        check("reset err0", {31'd0, err0}, 32'd0);
        check("reset err1", {31'd0, err1}, 32'd0);
        check("reset err2", {31'd0, err2}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            txn(vecs[i].sel, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, lat, rdv, ev, extra);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d rdata", i), rdv, vecs[i].exp_rd);
            check($sformatf("vec%0d err", i), {31'd0, ev}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d stray acks", i), extra, 0);
        end

        // Zero-wait read held through cycle 1 and dropped in cycle 2: one Ack, in cycle 1.
        @(posedge clk); #1;
        cur = 2'd1; re = 1'b1; addr = 30'h07;
        nack = 0; first = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ack1) begin
                nack++;
                if (first < 0) first = c;
            end
            if (c == 1) begin
                @(posedge clk); #1;
                re = 1'b0;
            end
        end
        check("w0 ack count", nack, 1);
        check("w0 ack cycle", first, 1);
        check("w0 rdata", rd1, 32'h13572468);

        // Command changed right after latching: original write still completes.
        @(posedge clk); #1;
        cur = 2'd0; we = 4'hF; addr = 30'h30; wdata = 32'h11111111;
        @(posedge clk); #1;
        we = 4'h0; addr = 30'h31; wdata = 32'h22222222;
        first = -1;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            if (ack0 && first < 0) first = c;
        end
        check("changed cmd ack cycle", first, 2);
        txn(2'd0, 4'h0, 1'b1, 30'h30, 32'h0, lat, rdv, ev, extra);
        check("changed cmd rdata", rdv, 32'h11111111);

        // Reset while a write sits in WAIT: the write is aborted.
        txn(2'd0, 4'hF, 1'b0, 30'h20, 32'h12345678, lat, rdv, ev, extra);
        @(posedge clk); #1;
        cur = 2'd0; we = 4'hF; addr = 30'h20; wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst = 1'b1; we = 4'h0;
        @(negedge clk);
        check("abort ack in reset", {31'd0, ack0}, 32'd0);
        check("abort rd in reset", rd0, 32'd0);
        @(negedge clk);
        check("abort ack in reset 2", {31'd0, ack0}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        txn(2'd0, 4'h0, 1'b1, 30'h20, 32'h0, lat, rdv, ev, extra);
        check("abort readback latency", lat, 2);
        check("abort readback", rdv, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
